// File: rtl/fir4_mac.sv
// fir4_mac: 4-tap FIR filter built around a single multiply-accumulate unit.
// A sample is accepted in IDLE, four products c[k]*x[k] are accumulated on
// four consecutive clocks (MAC), and the scaled, saturated result is held in
// HOLD until the consumer takes it.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_sample is valid this cycle
//   in_ready   : block accepts a sample this cycle (IDLE only)
//   in_sample  : signed 8-bit input sample
//   coef_we    : coefficient write strobe (honoured in IDLE only)
//   coef_addr  : tap index 0..3
//   coef_data  : signed Q0.7 coefficient
//   out_valid  : out_sample holds a result
//   out_ready  : consumer accepts the result this cycle
//   out_sample : signed 8-bit filtered result
//   busy       : high in MAC or HOLD
module fir4_mac (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sample,
  input  logic       coef_we,
  input  logic [1:0] coef_addr,
  input  logic [7:0] coef_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sample,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t            state;
  logic signed [7:0] x [4];
  logic signed [7:0] c [4];
  logic signed [17:0] acc;
  logic [1:0]        tap;

  logic signed [15:0] prod;
  logic signed [17:0] sum;
  logic signed [17:0] shr;
  logic [7:0]         result;

  // One product per clock, selected by the tap counter.
  always_comb begin
    prod = c[tap] * x[tap];
  end

  // Running sum including the current product; on the last tap this is the
  // full filter sum. Scaling is a floor shift by 7 followed by saturation.
  always_comb begin
    sum = acc + $signed({{2{prod[15]}}, prod});
    shr = sum >>> 7;
    if (shr > 18'sd127) begin
      result = 8'h7F;
    end else if (shr < -18'sd128) begin
      result = 8'h80;
    end else begin
      result = shr[7:0];
    end
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int unsigned i = 0; i < 4; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
      acc        <= '0;
      tap        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A coefficient write and a sample accept on the same edge both
          // land; the following MAC pass sees the new coefficient.
          if (coef_we) begin
            c[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            x[3]  <= x[2];
            x[2]  <= x[1];
            x[1]  <= x[0];
            x[0]  <= in_sample;
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          if (tap == 2'd3) begin
            out_sample <= result;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            tap <= tap + 2'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir4_mac.sv
// Self-checking bench for fir4_mac: a table of directed vectors (optional
// reset, optional coefficient load, one sample, expected result) plus
// hand-written sequences for reset, backpressure, coefficient lockout and
// collision, and reset during MAC.
module tb_fir4_mac;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sample;
  logic       coef_we;
  logic [1:0] coef_addr;
  logic [7:0] coef_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sample;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fir4_mac dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    logic        load;
    logic [31:0] coefs;   // {c0, c1, c2, c3}
    logic [7:0]  sample;
    logic [7:0]  expv;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // mode 0: plain; 1: write c0=127 on the accepting edge; 2: write c0=127
  // throughout MAC. Returns once out_valid is high (result not yet taken).
  task automatic send(input logic [7:0] s, input int mode, output int lat, output logic [7:0] res);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_sample = s;
    if (mode == 1) begin
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd127;
    end
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (mode == 2) begin
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd127;
    end
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    coef_we = 1'b0;
    res = out_sample;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic [7:0] res;
    int         seen;

    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b0;

    // do_rst, load, {c0,c1,c2,c3}, sample, expected
    vecs[0]  = '{1'b1, 1'b1, 32'h40201008, 8'd100, 8'd50};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        8'd0,   8'd25};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        8'd0,   8'd12};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        8'd0,   8'd6};
    vecs[4]  = '{1'b1, 1'b1, 32'h7F7F7F7F, 8'd127, 8'd126};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        8'd127, 8'd127};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        8'd127, 8'd127};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        8'd127, 8'd127};
    vecs[8]  = '{1'b1, 1'b1, 32'h7F7F7F7F, 8'h80,  8'h81};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        8'h80,  8'h80};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        8'h80,  8'h80};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        8'h80,  8'h80};
    vecs[12] = '{1'b1, 1'b1, 32'h40000000, 8'hFF,  8'hFF};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        8'd1,   8'd0};

    #1;
    check("reset_state", {out_valid, out_sample, in_ready, busy}, {1'b0, 8'd0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_rst) do_reset();
      if (vecs[i].load) begin
        for (int k = 0; k < 4; k++) begin
          logic [31:0] cw;
          cw = vecs[i].coefs;
          write_coef(2'(k), cw[31 - 8*k -: 8]);
        end
      end
      send(vecs[i].sample, 0, lat, res);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_result", i), res, vecs[i].expv);
      take();
    end

    // Backpressure, HOLD ignores in_valid and coef_we.
    do_reset();
    write_coef(2'd0, 8'd64);
    send(8'd100, 0, lat, res);
    check("bp_latency", lat, 4);
    check("bp_result", res, 8'd50);
    in_valid = 1'b1; in_sample = 8'h11;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd127;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {out_valid, in_ready, busy, out_sample}, {3'b101, 8'd50});
    end
    in_valid = 1'b0; coef_we = 1'b0;
    take();
    check("bp_release", {out_valid, in_ready, busy}, 3'b010);
    write_coef(2'd1, 8'd64);
    send(8'd100, 0, lat, res);
    check("hold_ignored_result", res, 8'd100);
    take();

    // Coefficient write during MAC is locked out.
    do_reset();
    write_coef(2'd0, 8'd64);
    send(8'd100, 2, lat, res);
    check("lockout_latency", lat, 4);
    check("lockout_result", res, 8'd50);
    take();
    send(8'd100, 0, lat, res);
    check("lockout_c0_kept", res, 8'd50);
    take();

    // Coefficient write colliding with accept takes effect for that pass.
    send(8'd100, 1, lat, res);
    check("collide_latency", lat, 4);
    check("collide_result", res, 8'd99);

    // Mid-cycle asynchronous reset while in HOLD with a result showing.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {out_valid, out_sample, in_ready, busy}, {1'b0, 8'd0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Reset pulsed in the second MAC cycle aborts the computation.
    write_coef(2'd0, 8'd64);
    write_coef(2'd1, 8'd64);
    in_valid = 1'b1; in_sample = 8'd100;
    seen = 0;
    while (!in_ready && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmac_reset_idle", {in_ready, busy}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midmac_no_output", seen, 0);
    send(8'd100, 0, lat, res);
    check("midmac_next_latency", lat, 4);
    check("midmac_next_result", res, 8'd0);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir4_mac.md
FIR4_MAC -- requirements
Module: fir4_mac

Interface
REQ-001 SHALL have no parameters: 4 taps, 8-bit samples and 8-bit coefficients are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_sample is valid this cycle.
REQ-005 in_ready  output  1  block accepts a sample this cycle.
REQ-006 in_sample  input  8  signed two's-complement input sample.
REQ-007 coef_we  input  1  coefficient write strobe.
REQ-008 coef_addr  input  2  tap index 0..3.
REQ-009 coef_data  input  8  signed coefficient, Q0.7 (value/128).
REQ-010 out_valid  output  1  out_sample holds a result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_sample  output  8  signed filtered result.
REQ-013 busy  output  1  high in MAC or HOLD states.

Function
REQ-014 SHALL hold a 4-entry delay line x[0..3] and a 4-entry coefficient file c[0..3], all signed 8-bit.
REQ-015 SHALL have FSM states IDLE, MAC, HOLD; in_ready = 1 only in IDLE; busy = not IDLE.
REQ-016 Input handshake: when in_valid and in_ready are high at an edge, x[3]<=x[2], x[2]<=x[1], x[1]<=x[0], x[0]<=in_sample; accumulator cleared; tap counter set to 0; FSM goes to MAC.
REQ-017 in_valid in MAC or HOLD SHALL be ignored, with no shift and no sample loss tracking. The producer holds the sample until in_ready.
REQ-018 MAC: one product per clock, acc += c[k]*x[k] for k = 0,1,2,3 on 4 consecutive edges.
REQ-019 Arithmetic: 16-bit signed products, 18-bit signed accumulator, which never overflows (|sum| <= 65536).
REQ-020 Result = acc arithmetically shifted right 7 (floor, no rounding), then saturated to [-128, +127].
REQ-021 On the 4th MAC edge: out_sample <= result, out_valid <= 1, FSM to HOLD. Latency is 4 clocks from the accepting edge to out_valid high.
REQ-022 HOLD: out_valid and out_sample SHALL stay stable until an edge with out_ready high. At that edge, out_valid <= 0 and FSM goes to IDLE. out_sample keeps its last value.
REQ-023 Minimum sample period is 6 clocks. There is no same-cycle input acceptance in HOLD.
REQ-024 Coefficient write: if coef_we is high in IDLE, then c[coef_addr] <= coef_data at that edge.
REQ-025 coef_we in MAC or HOLD SHALL be ignored, so coefficients are constant for a computation.
REQ-026 If coef_we and an input handshake occur at the same IDLE edge, both SHALL take effect. The following MAC SHALL use the new coefficient.
REQ-027 Tap counter is 2 bits and wraps 3->0 only on entry to MAC. There is no other wrap behaviour.
REQ-028 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for clk, force:
- FSM = IDLE
- x[], c[], accumulator, tap counter = 0
- out_valid = 0, out_sample = 0, busy = 0
- in_ready = 1
REQ-030 rst_n asserted during MAC or HOLD SHALL abort the computation, with no result emitted after release.
REQ-031 After rst_n deasserts, the first edge SHALL already accept in_valid / coef_we.

Verification
REQ-032 Reset: assert rst_n=0 mid-cycle -> out_valid=0, out_sample=0, in_ready=1, busy=0 before the next clk edge.
REQ-033 Impulse: c={64,32,16,8}; feed 100,0,0,0 with out_ready=1 -> out_sample = 50, 25, 12, 6.
  - Each result appears 4 clocks after its accept.
REQ-034 Saturation: c={127,127,127,127}.
  - Four samples of 127 -> 4th output = +127 (raw 504).
  - Reset, same coefficients, four samples of -128 -> 4th output = -128 (raw -508).
REQ-035 Backpressure: out_ready=0 for 10 cycles after out_valid rises.
  - out_valid=1, out_sample stable, in_ready=0 throughout.
  - out_ready=1 -> out_valid=0 next cycle, in_ready=1.
REQ-036 Coefficient lockout and collision:
  - c0=64, then write c0=127 during MAC of sample 100 -> result 50, c0 still 64.
  - coef_we c0=127 together with accepting sample 100 in IDLE -> result 99.
REQ-037 Reset mid-MAC: pulse rst_n low on the 2nd MAC cycle.
  - No out_valid follows.
  - Next sample 100 with c0=0 -> output 0, since the delay line and coefficients are cleared.
